// File: rtl/g15_acc_pkg.sv
// Shared types and defaults for the PL19/PL20 accessory sequencer.
// Holds character width, idle timeout, input FSM states, character type.
package g15_acc_pkg;

  localparam int ACC_CHAR_BITS    = 5;
  localparam int ACC_IDLE_TIMEOUT = 1024;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACTIVE
  } acc_in_state_t;

  typedef logic [ACC_CHAR_BITS-1:0] acc_char_t;

endpackage

// File: rtl/acc_out_deser.sv
// PL20 output deserialiser: assembly reg, idle timer, 2-entry FIFO.
// Ports: clk/rst, bit_in/shift in, valid/ready/data out, overflow/frag flags.
module acc_out_deser
  import g15_acc_pkg::*;
#(
  parameter int CHAR_BITS    = ACC_CHAR_BITS,
  parameter int IDLE_TIMEOUT = ACC_IDLE_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 shift,
  input  logic                 ready,
  input  logic                 clr_flags,
  output logic                 valid,
  output logic [CHAR_BITS-1:0] data,
  output logic                 overflow,
  output logic                 frag
);

  localparam int CW = $clog2(CHAR_BITS + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT);

  logic [CHAR_BITS-1:0] asm_q;
  logic [CHAR_BITS-1:0] nxt_char;
  logic [CW-1:0]        bcnt;
  logic [TW-1:0]        timer;
  logic [CHAR_BITS-1:0] mem0;
  logic [CHAR_BITS-1:0] mem1;
  logic [1:0]           fcnt;

  logic complete;
  logic pop;
  logic push;
  logic ovf_set;
  logic timeout;

  assign nxt_char = {asm_q[CHAR_BITS-2:0], bit_in};
  assign complete = shift & (bcnt == CW'(CHAR_BITS - 1));
  assign valid    = (fcnt != 2'd0);
  assign pop      = valid & ready;
  // a pop on the same edge frees the slot the new char needs
  assign ovf_set  = complete & (fcnt == 2'd2) & ~pop;
  assign push     = complete & ~ovf_set;
  assign timeout  = ~shift & (bcnt != '0) &
                    (timer == TW'(IDLE_TIMEOUT - 1));
  assign data     = mem0;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q    <= '0;
      bcnt     <= '0;
      timer    <= '0;
      mem0     <= '0;
      mem1     <= '0;
      fcnt     <= 2'd0;
      overflow <= 1'b0;
      frag     <= 1'b0;
    end else begin
      if (shift) begin
        asm_q <= nxt_char;
        timer <= '0;
        if (complete) bcnt <= '0;
        else          bcnt <= bcnt + CW'(1);
      end else if (bcnt != '0) begin
        if (timeout) begin
          bcnt  <= '0;
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end

      case ({push, pop})
        2'b10: begin
          if (fcnt == 2'd0) mem0 <= nxt_char;
          else              mem1 <= nxt_char;
          fcnt <= fcnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          fcnt <= fcnt - 2'd1;
        end
        2'b11: begin
          if (fcnt == 2'd1) begin
            mem0 <= nxt_char;
          end else begin
            mem0 <= mem1;
            mem1 <= nxt_char;
          end
        end
        default: ;
      endcase

      overflow <= ovf_set | (overflow & ~clr_flags);
      frag     <= timeout | (frag & ~clr_flags);
    end
  end

endmodule

// File: rtl/accessory_io_sequencer.sv
// PL19/PL20 accessory sequencer between control_switch and host bridge.
// Ports: PL19 start/stop/shift/input, PL20 bit/shift, host in/out handshakes, flags.
module accessory_io_sequencer
  import g15_acc_pkg::*;
#(
  parameter int CHAR_BITS    = ACC_CHAR_BITS,
  parameter int IDLE_TIMEOUT = ACC_IDLE_TIMEOUT
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 PL19_START_INPUT,
  input  logic                 PL19_STOP_INPUT,
  input  logic                 PL19_SHIFT_CMD_M20,
  output logic                 PL19_INPUT,
  input  logic                 PL20_OUTPUT,
  input  logic                 PL20_OUTPUT_SHIFT,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHAR_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHAR_BITS-1:0] out_data,
  output logic                 rd_active,
  output logic                 underrun,
  output logic                 overflow,
  output logic                 frag,
  input  logic                 clr_flags
);

  localparam int CW = $clog2(CHAR_BITS + 1);

  acc_in_state_t state;
  acc_in_state_t state_nx;

  logic                 rdy_en;
  logic                 hold_full;
  logic [CHAR_BITS-1:0] hold_data;
  logic [CHAR_BITS-1:0] sr;
  logic [CW-1:0]        cnt;

  logic active;
  logic shift_now;
  logic drop;
  logic sr_full;
  logic last_bit;
  logic sr_load;
  logic hs;

  always_ff @(posedge CLOCK) begin
    if (rst) state <= ACC_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC_IDLE: begin
        if (PL19_START_INPUT & ~PL19_STOP_INPUT)
          state_nx = ACC_ACTIVE;
      end
      ACC_ACTIVE: begin
        if (PL19_STOP_INPUT)
          state_nx = ACC_IDLE;
      end
      default: state_nx = ACC_IDLE;
    endcase
  end

  assign active    = (state == ACC_ACTIVE);
  // stop beats a same-cycle shift
  assign shift_now = active & PL19_SHIFT_CMD_M20 & ~PL19_STOP_INPUT;
  assign drop      = active & PL19_STOP_INPUT;
  assign sr_full   = (cnt != '0);
  assign last_bit  = shift_now & (cnt == CW'(1));
  // refill on the final-bit edge gives back-to-back chars with no gap
  assign sr_load   = hold_full & (~sr_full | last_bit | drop);
  assign in_ready  = rdy_en & ~hold_full & ~rst;
  assign hs        = in_valid & in_ready;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      rdy_en    <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      sr        <= '0;
      cnt       <= '0;
      underrun  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (sr_load) hold_full <= 1'b0;
      if (hs) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end
      if (sr_load) begin
        sr  <= hold_data;
        cnt <= CW'(CHAR_BITS);
      end else if (drop) begin
        cnt <= '0;
      end else if (shift_now & sr_full) begin
        sr  <= sr << 1;
        cnt <= cnt - CW'(1);
      end
      underrun <= (shift_now & ~sr_full) | (underrun & ~clr_flags);
    end
  end

  assign PL19_INPUT = active & sr_full & sr[CHAR_BITS-1];
  assign rd_active  = active;

  acc_out_deser #(
    .CHAR_BITS   (CHAR_BITS),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_deser (
    .clk      (CLOCK),
    .rst      (rst),
    .bit_in   (PL20_OUTPUT),
    .shift    (PL20_OUTPUT_SHIFT),
    .ready    (out_ready),
    .clr_flags(clr_flags),
    .valid    (out_valid),
    .data     (out_data),
    .overflow (overflow),
    .frag     (frag)
  );

endmodule

// File: doc/accessory_io_sequencer.md
Name: accessory_io_sequencer

Overview:
- Sequences the PL19/PL20 accessory interface of the control switch for a modern host-side character stream.
- Input path: after a ring-bell start, serialises host characters onto PL19_INPUT, one bit per PL19_SHIFT_CMD_M20 cycle, until stop.
- Output path: deserialises PL20_OUTPUT bits into host characters.
- Sits between control_switch and the FPGA host bridge; the only owner of PL19_INPUT.

Parameters:
- CHAR_BITS, 5, bits per character in both directions, MSB shifted first.
- IDLE_TIMEOUT, 1024, CLOCK cycles without a PL20 shift before a partial output character is discarded.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- PL19_START_INPUT  in  1  start-input request from control_switch.
- PL19_STOP_INPUT  in  1  stop-input request from control_switch.
- PL19_SHIFT_CMD_M20  in  1  high in each cycle the machine samples one input bit.
- PL19_INPUT  out  1  input data bit to control_switch.
- PL20_OUTPUT  in  1  output data bit.
- PL20_OUTPUT_SHIFT  in  1  high in each cycle PL20_OUTPUT holds a valid bit.
- in_valid / in_ready  in/out  1  host-to-G15 handshake.
- in_data  in  CHAR_BITS  host character.
- out_valid / out_ready  out/in  1  G15-to-host handshake.
- out_data  out  CHAR_BITS  assembled character.
- rd_active  out  1  input FSM is in ACTIVE.
- underrun, overflow, frag  out  1 each  sticky error flags.
- clr_flags  in  1  clears the sticky flags.

Behaviour:
- Reset: the input FSM goes to IDLE and the hold register, shift register and bit counters are emptied. All outputs read 0 while rst is high: PL19_INPUT, in_ready, out_valid, out_data, rd_active, underrun, overflow, frag. in_ready rises the cycle after rst falls.
- Input holding register (1 entry): in_ready = ~hold_full in any state. A handshake (in_valid & in_ready) loads it on the edge.
- Input shift register plus a bit counter (0..CHAR_BITS):
  - Loads from hold on any edge where the shift register is empty (or being emptied by a final-bit shift) and hold is full. This gives zero-bubble back-to-back characters.
  - A hold load and a host handshake may occur on the same edge.
- Input FSM, IDLE -> ACTIVE:
  - Taken on PL19_START_INPUT & ~PL19_STOP_INPUT.
  - START while ACTIVE is ignored.
- Input FSM, ACTIVE -> IDLE:
  - Taken on PL19_STOP_INPUT. STOP wins over simultaneous START or shift.
  - Any partially shifted character is discarded; hold is preserved.
- PL19_INPUT is combinational: PL19_INPUT = ACTIVE & sr_full & sr[MSB]. It is valid in the same cycle PL19_SHIFT_CMD_M20 is high, because control_switch samples it combinationally.
- On an edge with ACTIVE & PL19_SHIFT_CMD_M20:
  - The shift register shifts left one bit and the counter decrements.
  - If the shift register is empty, PL19_INPUT is 0 and underrun sets.
- PL19_SHIFT_CMD_M20 in IDLE is ignored; no flag is set.
- Output deserialiser:
  - On an edge with PL20_OUTPUT_SHIFT, PL20_OUTPUT shifts into the assembly register (MSB first) and the bit count increments.
  - At CHAR_BITS bits the character moves to a 2-entry output FIFO on the same edge and the count clears.
  - out_valid = FIFO not empty; out_data = FIFO head, registered.
  - If the FIFO is full on a completing shift, the character is dropped and overflow sets. A simultaneous pop frees a slot first, so no overflow occurs in that case.
- Idle timer:
  - Counts cycles since the last PL20_OUTPUT_SHIFT while a partial character exists.
  - At IDLE_TIMEOUT the partial character is discarded and frag sets.
  - The timer is cleared by any shift.
- Sticky flags: clr_flags clears all three. If a flag's set condition occurs on the same edge as clr_flags, the set wins.
- Reset mid-character: all partial data is lost. No flag is set by reset.

Decomposition:
- Package g15_acc_pkg holds:
  - the default CHAR_BITS and IDLE_TIMEOUT constants;
  - the input FSM enum acc_in_state_t {ACC_IDLE, ACC_ACTIVE};
  - the CHAR_BITS-wide character typedef acc_char_t.
- Sub-module acc_out_deser contains the assembly register, bit counter, idle timer and 2-entry FIFO, with overflow and frag outputs.
- The input path stays in the top module.

Test Plan:
- Serialise one character: preload in_data=5'b10110, pulse START, then drive 5 cycles of SHIFT_CMD_M20 -> PL19_INPUT = 1,0,1,1,0 in those cycles; in_ready high again after the load; underrun=0.
- Back-to-back characters: hold 5'b11111, then 5'b00001, then 10 consecutive shifts -> 1,1,1,1,1,0,0,0,0,1 with no gap cycle; the 11th shift gives PL19_INPUT=0 and underrun=1.
- Stop mid-character: START, send 5'b10101, shift 2 bits, then STOP and START together -> IDLE and rd_active=0. Next START plus a shift gives the next host character's MSB, not 5'b10101's bit 2.
- Output deserialise: 5 PL20 shifts carrying 1,1,0,0,1 -> out_valid=1 and out_data=5'b11001 the cycle after the 5th edge.
- Output overflow: out_ready=0 and 15 bits sent -> 2 characters held and overflow=1. clr_flags together with a 4th character's final bit -> overflow stays 1.
- Partial timeout: 3 PL20 bits then silence for 1024 cycles -> frag=1 and out_valid=0. Five fresh bits then produce a clean character.
